clk_div_multi: RTL and testbench

- N-channel, runtime-programmable clock divider; the parametrised successor of the fixed-ratio divider.
- Each channel produces a 50%-duty divided clock from clk_in, plus a one-cycle tick on each rising edge of that clock.
- Divisor changes are glitch-free: they take effect only at a toggle boundary.
- Per-channel enable with clean stop.
- Feeds display multiplexing, UART baud and LED blink logic from one shared block.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_channel.sv | 131 +++++++++++++
 rtl/clk_div_multi.sv | 42 ++++
 tb/tb_clk_div_multi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_HALF  = 50;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadow register, run/stop FSM and tick.
// Optional phase-align input `sync` is present when CLK_DIV_PHASE_ALIGN_EN is defined.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// IDLE     | stopped: counter=0, clk_out=0; pending value applied at once
// RUN      | enable high, counting half periods and toggling clk_out
// STOPPING | enable dropped while high; finish high phase, then go IDLE
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] half_in,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] eff;
  logic             boundary;
  logic             apply;

  // A programmed half period of 0 runs as 1 (clk_in/2).
  assign eff      = (active_q == '0) ? CNT_W'(1) : active_q;
  assign boundary = (counter_q >= eff - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    apply     = 1'b0;

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        clk_d     = 1'b0;
        apply     = pending_q;
        if (enable) state_d = RUN;
      end
      RUN, STOPPING: begin
        if (!enable && !clk_q) begin
          state_d   = IDLE;
          counter_d = '0;
          clk_d     = 1'b0;
        end else begin
          if (boundary) begin
            counter_d = '0;
            clk_d     = ~clk_q;
            tick_d    = ~clk_q;
            apply     = pending_q;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
          if (enable)        state_d = RUN;
          else if (boundary) state_d = IDLE;
          else               state_d = STOPPING;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
        clk_d     = 1'b0;
      end
    endcase

`ifdef CLK_DIV_PHASE_ALIGN_EN
    if (sync && enable) begin
      state_d   = RUN;
      counter_d = '0;
      clk_d     = 1'b0;
      tick_d    = 1'b0;
      apply     = pending_q;
    end
`endif

    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A load on the apply cycle stays pending for the following boundary.
    if (load) begin
      shadow_d  = half_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      active_q  <= CNT_W'(DEFAULT_HALF);
      shadow_q  <= CNT_W'(DEFAULT_HALF);
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable 50% duty clock divider with glitch-free divisor updates.
// Defining CLK_DIV_PHASE_ALIGN_EN adds the `sync` input for phase-aligned restarts.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*CNT_W-1:0] half_period,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic                  sync,
`endif
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable[i]),
      .load    (load[i]),
      .half_in (half_period[i*CNT_W +: CNT_W]),
`ifdef CLK_DIV_PHASE_ALIGN_EN
      .sync    (sync),
`endif
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi; expected periods are hand-computed from the divider rules.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = DEF_CNT_W;

  logic                  clk_in = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       enable;
  logic [N_CH-1:0]       load;
  logic [N_CH*CNT_W-1:0] half_period;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;
`ifdef CLK_DIV_PHASE_ALIGN_EN
  logic                  sync;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .half_period (half_period),
`ifdef CLK_DIV_PHASE_ALIGN_EN
    .sync        (sync),
`endif
    .clk_out     (clk_out),
    .tick        (tick),
    .pending     (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Cycles until clk_out[ch] reaches lvl, bounded so a dead channel cannot hang the run.
  task automatic measure(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (clk_out[ch] !== lvl && n < 200);
  endtask

  task automatic load_ch(input int ch, input int val);
    half_period[ch*CNT_W +: CNT_W] = CNT_W'(val);
    load[ch] = 1'b1;
    step(1);
    load[ch] = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    reset       = 1'b1;
    enable      = '0;
    load        = '0;
    half_period = '0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    sync        = 1'b0;
`endif
    step(2);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick",    32'(tick),    0);
    check("rst_pending", 32'(pending), 0);
    reset = 1'b0;

    // ch0 at default half period
    enable[0] = 1'b1;
    step(1);
    measure(0, 1'b1, n); check("ch0_first_rise", n, 50);
    check("ch0_tick_at_rise", 32'(tick[0]), 1);
    measure(0, 1'b0, n); check("ch0_high", n, 50);
    check("ch0_tick_at_fall", 32'(tick[0]), 0);
    measure(0, 1'b1, n); check("ch0_low", n, 50);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      cnt += int'(tick[0]);
    end
    check("ch0_ticks_per_100", cnt, 1);

    // ch1 at 10, reloaded to 3 mid-high
    load_ch(1, 10);
    check("ch1_idle_pending_set", 32'(pending[1]), 1);
    step(1);
    check("ch1_idle_pending_applied", 32'(pending[1]), 0);
    enable[1] = 1'b1;
    step(1);
    measure(1, 1'b1, n); check("ch1_first_rise", n, 10);
    step(3);
    load_ch(1, 3);
    check("ch1_pending_mid", 32'(pending[1]), 1);
    measure(1, 1'b0, n); check("ch1_high_rest", n, 6);
    check("ch1_pending_clear", 32'(pending[1]), 0);
    measure(1, 1'b1, n); check("ch1_new_low", n, 3);
    measure(1, 1'b0, n); check("ch1_new_high", n, 3);

    // ch2 programmed 0 -> clk_in/2
    load_ch(2, 0);
    step(1);
    enable[2] = 1'b1;
    step(1);
    measure(2, 1'b1, n); check("ch2_first_rise", n, 1);
    check("ch2_tick_a", 32'(tick[2]), 1);
    step(1);
    check("ch2_low", 32'(clk_out[2]), 0);
    check("ch2_tick_b", 32'(tick[2]), 0);
    step(1);
    check("ch2_high", 32'(clk_out[2]), 1);
    check("ch2_tick_c", 32'(tick[2]), 1);

    // ch3 at 20, enable dropped two cycles into high
    load_ch(3, 20);
    step(1);
    enable[3] = 1'b1;
    step(1);
    measure(3, 1'b1, n); check("ch3_first_rise", n, 20);
    step(2);
    enable[3] = 1'b0;
    measure(3, 1'b0, n); check("ch3_stop_high_rest", n, 18);
    step(25);
    check("ch3_idle_low", 32'(clk_out[3]), 0);
    enable[3] = 1'b1;
    step(1);
    measure(3, 1'b1, n); check("ch3_restart_rise", n, 20);

    // load on the exact boundary cycle of ch1 (half 3)
    measure(1, 1'b1, n);
    step(2);
    load_ch(1, 5);
    check("ch1_bnd_fell", 32'(clk_out[1]), 0);
    check("ch1_bnd_pending", 32'(pending[1]), 1);
    measure(1, 1'b1, n); check("ch1_bnd_old_low", n, 3);
    check("ch1_bnd_pending_clear", 32'(pending[1]), 0);
    measure(1, 1'b0, n); check("ch1_bnd_new_high", n, 5);
    measure(1, 1'b1, n); check("ch1_bnd_new_low", n, 5);

    // reset mid-period with a pending load
    load_ch(0, 7);
    check("ch0_pending_pre_rst", 32'(pending[0]), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_clk_out", 32'(clk_out), 0);
    check("midrst_tick",    32'(tick),    0);
    check("midrst_pending", 32'(pending), 0);
    step(1);
    measure(0, 1'b1, n); check("postrst_rise", n, 50);
    check("postrst_all_rise", 32'(clk_out), 32'hF);

`ifdef CLK_DIV_PHASE_ALIGN_EN
    half_period[0*CNT_W +: CNT_W] = CNT_W'(4);
    half_period[1*CNT_W +: CNT_W] = CNT_W'(8);
    load = 4'b0011;
    step(1);
    load = '0;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_clk_out", 32'(clk_out), 0);
    check("sync_pending", 32'(pending), 0);
    measure(0, 1'b1, n); check("sync_ch0_rise", n, 4);
    check("sync_ch1_low", 32'(clk_out[1]), 0);
    measure(1, 1'b1, n); check("sync_ch1_rise", n, 4);
    check("sync_ch1_tick", 32'(tick[1]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
